// File: rtl/trim_pkg.sv
// Shared constants for the bandgap trim SAR controller: FSM state codes,
// default geometry and serial-line idle levels used by display/readback logic.
package trim_pkg;

    localparam int unsigned TRIM_WIDTH       = 12;
    localparam int unsigned TRIM_CLK_DIV     = 25;
    localparam int unsigned TRIM_SETTLE      = 1000;
    localparam int unsigned TRIM_FILTER_TAPS = 3;

    localparam logic TRIM_DOUT_IDLE  = 1'b0;
    localparam logic TRIM_ENCLK_IDLE = 1'b0;

    localparam int unsigned STATE_W = 3;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_DECIDE = 3'd4;
    localparam logic [2:0] ST_FINAL  = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/trim_sar_ctrl_if.sv
// Handshake, comparator and trim-register serial lines of trim_sar_ctrl.
interface trim_sar_ctrl_if
    import trim_pkg::*;
#(
    parameter int unsigned WIDTH = TRIM_WIDTH
);
    logic             START;
    logic             MAN_LD;
    logic [WIDTH-1:0] MAN_CODE;
    logic             CMP;
    logic             DOUT;
    logic             ENCLK;
    logic [WIDTH-1:0] CODE;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START, MAN_LD, MAN_CODE, CMP,
        input  DOUT, ENCLK, CODE, BUSY, DONE
    );

    modport slave (
        input  START, MAN_LD, MAN_CODE, CMP,
        output DOUT, ENCLK, CODE, BUSY, DONE
    );
endinterface

// File: rtl/trim_ser_tx.sv
// Trim-register frame serialiser: LSB-first DOUT, ENCLK low then high per bit,
// frame_done_c flags the last cycle of the final bit.
module trim_ser_tx
    import trim_pkg::*;
#(
    parameter int unsigned WIDTH   = TRIM_WIDTH,
    parameter int unsigned CLK_DIV = TRIM_CLK_DIV
) (
    input  logic             CLK50,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] code,
    output logic             dout,
    output logic             enclk,
    output logic             frame_done_c
);
    localparam int unsigned BIT_CYC = 2 * CLK_DIV;
    localparam int unsigned PH_W    = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int unsigned IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             active;
    logic [WIDTH-1:0] shreg;
    logic [PH_W-1:0]  phase;
    logic [IDX_W-1:0] bit_idx;
    logic             bit_end_c;

    assign bit_end_c    = active && (phase == PH_W'(BIT_CYC - 1));
    assign frame_done_c = bit_end_c && (bit_idx == IDX_W'(WIDTH - 1));

    // DOUT is presented for the whole bit; ENCLK rises halfway through it
    always_ff @(posedge CLK50) begin
        if (RST) begin
            active  <= 1'b0;
            shreg   <= '0;
            phase   <= '0;
            bit_idx <= '0;
            dout    <= TRIM_DOUT_IDLE;
            enclk   <= TRIM_ENCLK_IDLE;
        end else if (load) begin
            active  <= 1'b1;
            shreg   <= code;
            phase   <= '0;
            bit_idx <= '0;
            dout    <= code[0];
            enclk   <= 1'b0;
        end else if (active) begin
            if (bit_end_c) begin
                phase <= '0;
                enclk <= 1'b0;
                if (frame_done_c) begin
                    active <= 1'b0;
                    dout   <= TRIM_DOUT_IDLE;
                end else begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 1'b1;
                    dout    <= shreg[1];
                end
            end else begin
                phase <= phase + 1'b1;
                if (phase == PH_W'(CLK_DIV - 1)) begin
                    enclk <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/trim_sar_ctrl.sv
// Successive-approximation bandgap trim controller with manual frame load.
// Define TRIM_SAR_CMP_FILTER_EN to decide on a 3-sample majority of CMP.
module trim_sar_ctrl
    import trim_pkg::*;
#(
    parameter int unsigned WIDTH   = TRIM_WIDTH,
    parameter int unsigned CLK_DIV = TRIM_CLK_DIV,
    parameter int unsigned SETTLE  = TRIM_SETTLE
) (
    input  logic            CLK50,
    input  logic            RST,
    trim_sar_ctrl_if.slave  bus
);
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CNT_W = $clog2(SETTLE);
`ifdef TRIM_SAR_CMP_FILTER_EN
    localparam int unsigned HIST_W = TRIM_FILTER_TAPS;
`else
    localparam int unsigned HIST_W = 1;
`endif

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_n;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   man_code_q;
    logic [WIDTH-1:0]   frame_q;
    logic [WIDTH-1:0]   code_q;
    logic [IDX_W-1:0]   bit_i;
    logic [CNT_W-1:0]   settle_cnt;
    logic [HIST_W-1:0]  hist;
    logic               manual_q;
    logic               final_q;
    logic               busy_q;
    logic               done_q;
    logic               cmp_s1;
    logic               cmp_s2;

    logic               start_c;
    logic               man_c;
    logic               load_c;
    logic               dec_c;
    logic               frame_done_c;
    logic [WIDTH-1:0]   onehot_c;
    logic [WIDTH-1:0]   frame_code_c;

    assign onehot_c = WIDTH'(1) << bit_i;

`ifdef TRIM_SAR_CMP_FILTER_EN
    assign dec_c = maj3(hist);
`else
    assign dec_c = hist[0];
`endif

    always_comb begin
        if (state_q == ST_FINAL) begin
            frame_code_c = result;
        end else if (manual_q) begin
            frame_code_c = man_code_q;
        end else begin
            frame_code_c = result | onehot_c;
        end
    end

    always_ff @(posedge CLK50) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // START wins over MAN_LD; both are only looked at while idle
    always_comb begin
        state_n = state_q;
        start_c = 1'b0;
        man_c   = 1'b0;
        load_c  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.START) begin
                    start_c = 1'b1;
                    state_n = ST_LOAD;
                end else if (bus.MAN_LD) begin
                    man_c   = 1'b1;
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD, ST_FINAL: begin
                load_c  = 1'b1;
                state_n = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (frame_done_c) begin
                    if (manual_q) begin
                        state_n = ST_IDLE;
                    end else if (final_q) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == CNT_W'(SETTLE - 1)) begin
                    state_n = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                state_n = (bit_i == '0) ? ST_FINAL : ST_LOAD;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK50) begin
        if (RST) begin
            result     <= '0;
            man_code_q <= '0;
            frame_q    <= '0;
            code_q     <= '0;
            bit_i      <= IDX_W'(WIDTH - 1);
            settle_cnt <= '0;
            hist       <= '0;
            manual_q   <= 1'b0;
            final_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cmp_s1     <= 1'b0;
            cmp_s2     <= 1'b0;
        end else begin
            cmp_s1 <= bus.CMP;
            cmp_s2 <= cmp_s1;
            busy_q <= !((state_n == ST_IDLE) || (state_n == ST_DONE));
            done_q <= (state_n == ST_DONE);
            if (start_c) begin
                result   <= '0;
                bit_i    <= IDX_W'(WIDTH - 1);
                manual_q <= 1'b0;
                final_q  <= 1'b0;
            end
            if (man_c) begin
                man_code_q <= bus.MAN_CODE;
                manual_q   <= 1'b1;
                final_q    <= 1'b0;
            end
            if (load_c) begin
                frame_q <= frame_code_c;
                final_q <= (state_q == ST_FINAL);
            end
            if ((state_q == ST_SHIFT) && frame_done_c) begin
                code_q     <= frame_q;
                settle_cnt <= '0;
            end
            // synchronised CMP history; the tail end of SETTLE feeds the decision
            if (state_q == ST_SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
                hist       <= HIST_W'({hist, cmp_s2});
            end
            if (state_q == ST_DECIDE) begin
                result <= dec_c ? (frame_q & ~onehot_c) : frame_q;
                if (bit_i != '0) begin
                    bit_i <= bit_i - 1'b1;
                end
            end
        end
    end

    trim_ser_tx #(
        .WIDTH   (WIDTH),
        .CLK_DIV (CLK_DIV)
    ) u_ser_tx (
        .CLK50        (CLK50),
        .RST          (RST),
        .load         (load_c),
        .code         (frame_code_c),
        .dout         (bus.DOUT),
        .enclk        (bus.ENCLK),
        .frame_done_c (frame_done_c)
    );

    assign bus.CODE = code_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;

endmodule

// File: tb/tb_trim_sar_ctrl.sv
// Bench for trim_sar_ctrl: receiving shift register on ENCLK, comparator model
// CMP = (received code > target), binary-search reference for every frame.
module tb_trim_sar_ctrl;
    import trim_pkg::*;

    localparam int unsigned W          = 12;
    localparam int unsigned CD         = 2;
    localparam int unsigned ST         = 4;
    localparam int unsigned FRAME      = W * 2 * CD;
    localparam int unsigned SEARCH_CYC = W * (1 + FRAME + ST + 1) + 1 + FRAME;

    logic CLK50 = 1'b0;
    logic RST   = 1'b1;

    trim_sar_ctrl_if #(.WIDTH(W)) bus ();

    trim_sar_ctrl #(
        .WIDTH   (W),
        .CLK_DIV (CD),
        .SETTLE  (ST)
    ) dut (
        .CLK50 (CLK50),
        .RST   (RST),
        .bus   (bus)
    );

    always #5 CLK50 = ~CLK50;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] target     = '0;
    logic         cmp_glitch = 1'b0;
    logic [W-1:0] rx         = '0;
    int           rises      = 0;
    logic [W-1:0] rx_log[$];

    // trim register receiver and comparator
    always @(posedge bus.ENCLK) begin
        rx = {bus.DOUT, rx[W-1:1]};
        rx_log.push_back(rx);
        rises++;
    end

    assign bus.CMP = (rx > target) ^ cmp_glitch;

    task automatic tick();
        @(posedge CLK50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic frame_word(input int base, input int k, output logic [W-1:0] w);
        int idx;
        idx = base + k * int'(W) + int'(W) - 1;
        if (idx < rx_log.size()) w = rx_log[idx];
        else w = 'x;
    endtask

    task automatic run_search(input logic [W-1:0] tgt, input bit with_man,
                              input bit poke, input bit glitch);
        logic [W-1:0] res;
        logic [W-1:0] trial;
        logic [W-1:0] got;
        logic [W-1:0] exp_q[$];
        int base;
        int cyc;
        res = '0;
        for (int i = W - 1; i >= 0; i--) begin
            trial = res | (W'(1) << i);
            exp_q.push_back(trial);
            if (trial <= tgt) res = trial;
        end
        exp_q.push_back(res);

        target       = tgt;
        base         = rises;
        bus.START    = 1'b1;
        bus.MAN_LD   = with_man;
        bus.MAN_CODE = 12'h3C3;
        tick();
        bus.START  = 1'b0;
        bus.MAN_LD = 1'b0;
        check("search_busy_on_accept", bus.BUSY, 1);
        check("search_done_cleared", bus.DONE, 0);

        cyc = 0;
        while (!bus.DONE && cyc < int'(2 * SEARCH_CYC)) begin
            tick();
            cyc++;
            if (poke && cyc == 50) begin bus.START = 1'b1; bus.MAN_LD = 1'b1; end
            if (poke && cyc == 51) begin bus.START = 1'b0; bus.MAN_LD = 1'b0; end
            if (glitch && cyc == 50) cmp_glitch = 1'b1;
            if (glitch && cyc == 51) cmp_glitch = 1'b0;
        end
        check("search_cycles", cyc, SEARCH_CYC);
        check("search_code", bus.CODE, res);
        check("search_done", bus.DONE, 1);
        check("search_busy_low", bus.BUSY, 0);
        check("search_lines_idle", {bus.DOUT, bus.ENCLK}, 0);
        check("search_enclk_rises", rises - base, 13 * W);
        for (int k = 0; k < 13; k++) begin
            frame_word(base, k, got);
            check($sformatf("search_frame%0d", k), got, exp_q[k]);
        end
    endtask

    initial begin
        logic [W-1:0] mc;
        logic [W-1:0] got;
        int base;
        int cyc;

        bus.START    = 1'b0;
        bus.MAN_LD   = 1'b0;
        bus.MAN_CODE = '0;
        RST = 1'b1;
        tick(); tick(); tick();
        RST = 1'b0;
        check("rst_dout", bus.DOUT, 0);
        check("rst_enclk", bus.ENCLK, 0);
        check("rst_code", bus.CODE, 0);
        check("rst_busy", bus.BUSY, 0);
        check("rst_done", bus.DONE, 0);

        // nominal search with known early trials
        base = rises;
        run_search(12'h5A3, 1'b0, 1'b0, 1'b0);
        frame_word(base, 0, got); check("trial1", got, 12'h800);
        frame_word(base, 1, got); check("trial2", got, 12'h400);
        frame_word(base, 2, got); check("trial3", got, 12'h600);
        check("target_5a3", bus.CODE, 12'h5A3);

        // manual load from DONE, cycle-exact frame shape
        mc           = 12'hA5C;
        base         = rises;
        bus.MAN_LD   = 1'b1;
        bus.MAN_CODE = mc;
        tick();
        bus.MAN_LD   = 1'b0;
        bus.MAN_CODE = '0;
        check("man_done_cleared", bus.DONE, 0);
        check("man_busy", bus.BUSY, 1);
        for (int c = 0; c < int'(FRAME); c++) begin
            tick();
            check($sformatf("man_dout_c%0d", c), bus.DOUT, mc[c / int'(2 * CD)]);
            check($sformatf("man_enclk_c%0d", c), bus.ENCLK,
                  ((c % int'(2 * CD)) >= int'(CD)) ? 1 : 0);
            if (c == int'(FRAME) - 1) check("man_busy_before_end", bus.BUSY, 1);
        end
        tick();
        check("man_busy_low_49", bus.BUSY, 0);
        check("man_done", bus.DONE, 0);
        check("man_code", bus.CODE, 12'hA5C);
        check("man_rx", rx, 12'hA5C);
        check("man_rises", rises - base, W);
        check("man_lines_idle", {bus.DOUT, bus.ENCLK}, 0);

        // boundaries
        run_search(12'hFFF, 1'b0, 1'b0, 1'b0);
        check("target_fff", bus.CODE, 12'hFFF);
        run_search(12'h000, 1'b0, 1'b0, 1'b0);
        check("target_000_rx", rx, 12'h000);

        // collisions
        run_search(12'h3C7, 1'b1, 1'b0, 1'b0);
        run_search(12'h19E, 1'b0, 1'b1, 1'b0);

        // reset in the middle of bit 5 of frame 3, then recover
        target    = 12'h6D2;
        base      = rises;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        cyc = 0;
        while ((rises - base) < 30 && cyc < 1000) begin
            tick();
            cyc++;
        end
        check("midreset_reached", rises - base, 30);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("midreset_dout", bus.DOUT, 0);
        check("midreset_enclk", bus.ENCLK, 0);
        check("midreset_code", bus.CODE, 0);
        check("midreset_busy", bus.BUSY, 0);
        check("midreset_done", bus.DONE, 0);
        tick();
        check("midreset_stays_idle", bus.BUSY, 0);
        run_search(12'h6D2, 1'b0, 1'b0, 1'b0);

        // random targets
        for (int r = 0; r < 3; r++) begin
            run_search(W'($urandom_range(0, 4095)), 1'b0, 1'b0, 1'b0);
        end

`ifdef TRIM_SAR_CMP_FILTER_EN
        run_search(12'h5A3, 1'b0, 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trim_sar_ctrl.md
# trim_sar_ctrl

Successive-approximation trim controller for the bandgap trim path. Runs a binary search over the WIDTH-bit trim code: each trial code is serialised to the trim register as an ENCLK/DOUT frame, the comparator is sampled after a settle interval, and the bit is kept or cleared. It also accepts a manual single-frame load, and reports the final code for display and readback.

## Interface
- WIDTH, 12: trim code width; also the number of ENCLK pulses per frame.
- CLK_DIV, 25: CLK50 cycles per serial half-bit (ENCLK low, then ENCLK high).
- SETTLE, 1000: CLK50 cycles between frame end and comparator decision; must be ≥3.
- CLK50  in  1  system clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- START  in  1  level; sampled in IDLE/DONE; starts a SAR search.
- MAN_LD  in  1  level; sampled in IDLE/DONE; sends MAN_CODE as one frame.
- MAN_CODE  in  WIDTH  manual code, captured on MAN_LD acceptance.
- CMP  in  1  comparator: 1 = trimmed output above target; treat as asynchronous, 2-flop synchronised.
- DOUT  out  1  serial data, LSB first, registered.
- ENCLK  out  1  serial shift strobe, registered; receiver shifts on its rising edge.
- CODE  out  WIDTH  last fully shifted code, or the search result.
- BUSY  out  1  high in any state except IDLE/DONE.
- DONE  out  1  high in DONE; cleared on the next acceptance.

## Operation
- States: IDLE, LOAD, SHIFT, SETTLE, DECIDE, FINAL, DONE.
- Reset: state IDLE; DOUT=0, ENCLK=0, CODE=0, BUSY=0, DONE=0; result=0; bit index i=WIDTH-1.
- IDLE/DONE with START=1:
  - result=0, i=WIDTH-1, go to LOAD.
  - START takes priority when START and MAN_LD are both high.
- IDLE/DONE with MAN_LD=1 and START=0:
  - Capture MAN_CODE and go to LOAD in manual mode.
  - After SHIFT: CODE=MAN_CODE, go to IDLE, DONE=0.
- LOAD (1 cycle):
  - Search mode: shift register = result | (1<<i).
  - Manual mode: shift register = captured MAN_CODE.
- SHIFT, for bits k=0..WIDTH-1, each lasting 2*CLK_DIV cycles:
  - DOUT = shreg[0] for the whole bit.
  - ENCLK=0 for the first CLK_DIV cycles, then 1 for the next CLK_DIV.
  - Shift right at bit end.
  - After bit WIDTH-1: DOUT=0, ENCLK=0; CODE = the frame code.
- SETTLE: count SETTLE cycles, then DECIDE.
- DECIDE (1 cycle):
  - If the decision bit is 1, clear bit i of the trial; otherwise keep it.
  - Store the trial into result.
  - If i==0, go to FINAL; else i=i-1 and go to LOAD.
- FINAL: LOAD + SHIFT of result (no settle); CODE=result; then DONE.
- START/MAN_LD while BUSY: ignored, never queued.
- RST mid-frame: at the next edge all outputs return to reset values. A partial frame is abandoned; the receiver is resynchronised by the next full frame.

## Timing
- Acceptance → LOAD on the next edge.
- First DOUT bit valid 2 cycles after acceptance; first ENCLK rise at CLK_DIV cycles after that.
- Frame: WIDTH*2*CLK_DIV cycles; exactly WIDTH ENCLK rising edges; no glitches between frames.
- Search: WIDTH*(1 + WIDTH*2*CLK_DIV + SETTLE + 1) + 1 + WIDTH*2*CLK_DIV cycles from acceptance to DONE.
- Manual: 1 + WIDTH*2*CLK_DIV cycles to IDLE.
- CMP path: 2-cycle synchroniser latency, included within SETTLE.

## Configuration
- TRIM_SAR_CMP_FILTER_EN defined: decision bit = majority of synchronised CMP sampled on the last 3 SETTLE cycles.
- TRIM_SAR_CMP_FILTER_EN undefined: decision bit = synchronised CMP on the last SETTLE cycle.
- Frame timing is identical either way.

## Structure
- Package trim_pkg:
  - state enumeration.
  - TRIM_WIDTH default.
  - serial constants shared with the display/readback logic.
- Sub-module trim_ser_tx: frame serialiser.
  - Inputs: load pulse + WIDTH code.
  - Outputs: DOUT, ENCLK, frame_done pulse.
  - Owns the bit/phase counters.
- trim_sar_ctrl keeps the FSM, result/bit index, settle counter and CMP synchroniser/filter.

## Test plan
Bench params: WIDTH=12, CLK_DIV=2, SETTLE=4. Model: CMP = (last received code > target), with a receiving shift register modelled on ENCLK.
- Reset: after RST, DOUT=0, ENCLK=0, CODE=0, BUSY=0, DONE=0.
- Search, target 0x5A3: START pulse → 13 frames, DONE=1, CODE=0x5A3; each frame has 12 ENCLK rises; trial frames 1–3 are 0x800, 0x400, 0x600.
- Search boundaries:
  - Target 0xFFF → CODE=0xFFF.
  - Target 0x000 → CODE=0x000; final received word 0x000.
- Manual load: MAN_LD with MAN_CODE=0xA5C in IDLE → one frame; receiver holds 0xA5C; CODE=0xA5C; BUSY low 49 cycles after acceptance; DONE=0.
- Collisions:
  - START+MAN_LD together → search runs.
  - START or MAN_LD pulsed mid-SETTLE → ignored, no extra frames.
- Reset mid-SHIFT (bit 5 of frame 3) → next cycle all outputs 0, state IDLE; a subsequent START completes with the correct result.
- With TRIM_SAR_CMP_FILTER_EN: 1-cycle CMP glitch on the final SETTLE cycle → decision unchanged.
